// File: rtl/mem_stage_hs.sv
// MEM pipeline stage with valid/ready handshakes, a self-driven variable-latency data-memory port,
// prioritised store-data bypass and a bounded wait for load responses.
module mem_stage_hs #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int CTRL_W  = 64,
  parameter int BYP_CH  = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_alu,
  input  logic [DATA_W-1:0]        in_regb,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic                     in_load,
  input  logic                     in_store,
  input  logic [BYP_CH-1:0]        byp_valid,
  input  logic [BYP_CH*DATA_W-1:0] byp_data,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_rvalid,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_alu,
  output logic [DATA_W-1:0]        out_rdata,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic                     out_err
);
  timeunit 1ns;
  timeprecision 1ps;

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              load_q;
  logic              store_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] byp_sel;
  logic              accept;
  logic              in_mem;
  logic              cnt_last;

  assign accept   = in_valid & in_ready;
  assign in_mem   = in_load | in_store;
  assign cnt_last = (cnt == CNT_LAST);

  // Lowest-index active channel wins, so scan from the top down and let lower indices override.
  always_comb begin
    byp_sel = in_regb;
    for (int k = BYP_CH - 1; k >= 0; k--) begin
      if (byp_valid[k]) byp_sel = byp_data[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = in_mem ? ISSUE : DONE;
      end
      ISSUE: begin
        mem_req   = 1'b1;
        mem_we    = store_q;
        state_nxt = load_q ? WAIT : DONE;
      end
      WAIT: begin
        if (mem_rvalid || cnt_last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready  = 1'b1;
          state_nxt = in_valid ? (in_mem ? ISSUE : DONE) : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A new accept always restarts the result as "no load data, no error".
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      out_alu   <= '0;
      out_ctrl  <= '0;
      out_rdata <= '0;
      out_err   <= 1'b0;
      load_q    <= 1'b0;
      store_q   <= 1'b0;
      wdata_q   <= '0;
      cnt       <= '0;
    end else begin
      if (accept) begin
        out_alu   <= in_alu;
        out_ctrl  <= in_ctrl;
        load_q    <= in_load;
        store_q   <= in_store & ~in_load;
        wdata_q   <= byp_sel;
        out_rdata <= '0;
        out_err   <= 1'b0;
      end else if (state == DONE && out_ready) begin
        out_err <= 1'b0;
      end

      if (state == ISSUE) cnt <= '0;

      if (state == WAIT) begin
        if (mem_rvalid) begin
          out_rdata <= mem_rdata;
        end else if (cnt_last) begin
          out_err   <= 1'b1;
          out_rdata <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign mem_wdata = wdata_q;

  generate
    if (ADDR_W <= DATA_W) begin : g_addr_trunc
      assign mem_addr = out_alu[ADDR_W-1:0];
    end else begin : g_addr_ext
      assign mem_addr = {{(ADDR_W - DATA_W){1'b0}}, out_alu};
    end
  endgenerate

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: a transaction-level model predicts every result and memory
// request; a per-cycle compare process checks the DUT against it, plus literal expectations.
module tb_mem_stage_hs;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int CTRL_W  = 64;
  localparam int BYP_CH  = 2;
  localparam int TIMEOUT = 15;

  logic                     clk = 1'b0;
  logic                     clr = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_alu = '0;
  logic [DATA_W-1:0]        in_regb = '0;
  logic [CTRL_W-1:0]        in_ctrl = '0;
  logic                     in_load = 1'b0;
  logic                     in_store = 1'b0;
  logic [BYP_CH-1:0]        byp_valid = '0;
  logic [BYP_CH*DATA_W-1:0] byp_data = '0;
  logic                     mem_req;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic                     mem_rvalid = 1'b0;
  logic [DATA_W-1:0]        mem_rdata = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic [DATA_W-1:0]        out_alu;
  logic [DATA_W-1:0]        out_rdata;
  logic [CTRL_W-1:0]        out_ctrl;
  logic                     out_err;

  mem_stage_hs #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .BYP_CH(BYP_CH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu(in_alu), .in_regb(in_regb), .in_ctrl(in_ctrl),
    .in_load(in_load), .in_store(in_store),
    .byp_valid(byp_valid), .byp_data(byp_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu(out_alu), .out_rdata(out_rdata), .out_ctrl(out_ctrl), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rdata;
    logic [CTRL_W-1:0] ctrl;
    logic              err;
    int                lat;
    int                acc;
  } res_t;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mreq_t;

  typedef struct {
    int                lat;
    logic [DATA_W-1:0] data;
  } plan_t;

  res_t  exp_q[$];
  mreq_t mreq_q[$];
  plan_t plan_q[$];
  bit    front_seen = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  int                cur_lat = 0;
  logic [DATA_W-1:0] cur_rdata = '0;
  int                mem_req_count = 0;
  logic              last_we = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [DATA_W-1:0] last_wdata = '0;
  logic [DATA_W-1:0] done_alu = '0;
  logic [DATA_W-1:0] done_rdata = '0;
  logic              done_err = 1'b0;
  int                done_lat = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Store data the stage must use: first channel (counting up from 0) that is valid, else regb.
  function automatic logic [DATA_W-1:0] model_wdata(input logic [BYP_CH-1:0] bv,
                                                    input logic [BYP_CH*DATA_W-1:0] bd,
                                                    input logic [DATA_W-1:0] regb);
    logic [DATA_W-1:0] w;
    bit found;
    w = regb;
    found = 1'b0;
    for (int k = 0; k < BYP_CH; k++) begin
      if (!found && bv[k]) begin
        w = bd[k*DATA_W +: DATA_W];
        found = 1'b1;
      end
    end
    return w;
  endfunction

  // Compare process: each negedge, check held results and memory requests, then log new accepts.
  always @(negedge clk) begin
    if (!clr) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          if (!front_seen) begin
            front_seen = 1'b1;
            done_lat = cyc - exp_q[0].acc;
            checkOutput("latency", 64'(cyc - exp_q[0].acc), 64'(exp_q[0].lat));
          end
          checkOutput("out_alu", 64'(out_alu), 64'(exp_q[0].alu));
          checkOutput("out_rdata", 64'(out_rdata), 64'(exp_q[0].rdata));
          checkOutput("out_ctrl", out_ctrl, exp_q[0].ctrl);
          checkOutput("out_err", 64'(out_err), 64'(exp_q[0].err));
          if (out_ready) begin
            done_alu   = out_alu;
            done_rdata = out_rdata;
            done_err   = out_err;
            void'(exp_q.pop_front());
            front_seen = 1'b0;
          end
        end
      end

      if (mem_req) begin
        mem_req_count++;
        if (mreq_q.size() == 0) begin
          checkOutput("unexpected_mem_req", 64'(mem_req), 64'd0);
        end else begin
          checkOutput("mem_we", 64'(mem_we), 64'(mreq_q[0].we));
          checkOutput("mem_addr", 64'(mem_addr), 64'(mreq_q[0].addr));
          if (mreq_q[0].we) checkOutput("mem_wdata", 64'(mem_wdata), 64'(mreq_q[0].wdata));
          void'(mreq_q.pop_front());
        end
        last_we    = mem_we;
        last_addr  = mem_addr;
        last_wdata = mem_wdata;
      end

      if (in_valid && in_ready) begin
        res_t r;
        bit is_load, is_store;
        is_load  = in_load;
        is_store = in_store && !in_load;
        r.alu   = in_alu;
        r.ctrl  = in_ctrl;
        r.acc   = cyc;
        r.rdata = '0;
        r.err   = 1'b0;
        if (is_load) begin
          if (cur_lat >= 1 && cur_lat <= TIMEOUT) begin
            r.lat   = 2 + cur_lat;
            r.rdata = cur_rdata;
          end else begin
            r.lat = 2 + TIMEOUT;
            r.err = 1'b1;
          end
          plan_q.push_back('{lat: cur_lat, data: cur_rdata});
        end else if (is_store) begin
          r.lat = 2;
        end else begin
          r.lat = 1;
        end
        if (is_load || is_store)
          mreq_q.push_back('{we: is_store, addr: in_alu[ADDR_W-1:0],
                             wdata: model_wdata(byp_valid, byp_data, in_regb)});
        exp_q.push_back(r);
      end
    end
  end

  // Memory responder: answers a load in its L-th wait cycle; L<1 means never.
  always begin
    @(negedge clk);
    if (!clr && mem_req && !mem_we && plan_q.size() > 0) begin
      plan_t p;
      p = plan_q.pop_front();
      if (p.lat >= 1) begin
        @(posedge clk);
        repeat (p.lat - 1) @(posedge clk);
        #1;
        mem_rvalid = 1'b1;
        mem_rdata  = p.data;
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
      end
    end
  end

  task automatic applyReset();
    clr = 1'b1;
    exp_q.delete();
    mreq_q.delete();
    plan_q.delete();
    front_seen = 1'b0;
  endtask

  task automatic applyStimulus(input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] regb,
                               input logic [CTRL_W-1:0] ctrl, input logic ld, input logic st,
                               input logic [BYP_CH-1:0] bv, input logic [DATA_W-1:0] b0,
                               input logic [DATA_W-1:0] b1, input int lat,
                               input logic [DATA_W-1:0] rd);
    bit ok;
    in_alu    = alu;
    in_regb   = regb;
    in_ctrl   = ctrl;
    in_load   = ld;
    in_store  = st;
    byp_valid = bv;
    byp_data  = {b1, b0};
    cur_lat   = lat;
    cur_rdata = rd;
    in_valid  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) checkOutput("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) ok = 1'b1;
    end
    if (!ok) checkOutput("drain_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    #1 applyReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
    checkOutput("rst_mem_we", 64'(mem_we), 64'd0);
    checkOutput("rst_out_alu", 64'(out_alu), 64'd0);
    checkOutput("rst_out_ctrl", out_ctrl, 64'd0);
    checkOutput("rst_out_err", 64'(out_err), 64'd0);
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    $display("[TB] ALU op");
    base = mem_req_count;
    applyStimulus(32'h0000_0042, 32'h0, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 0, 32'h0);
    waitDrain();
    checkOutput("t1_alu", 64'(done_alu), 64'h42);
    checkOutput("t1_lat", 64'(done_lat), 64'd1);
    checkOutput("t1_no_mem_req", 64'(mem_req_count - base), 64'd0);

    $display("[TB] stores with bypass");
    base = mem_req_count;
    applyStimulus(32'h0000_0200, 32'h1, 64'h5, 1'b0, 1'b1, 2'b11, 32'hAAAA_0000, 32'hBBBB_0000, 0, 32'h0);
    waitDrain();
    checkOutput("t2_wdata_ch0", 64'(last_wdata), 64'hAAAA_0000);
    checkOutput("t2_we", 64'(last_we), 64'd1);
    checkOutput("t2_one_req", 64'(mem_req_count - base), 64'd1);
    checkOutput("t2_lat", 64'(done_lat), 64'd2);
    applyStimulus(32'h0000_0204, 32'h1, 64'h6, 1'b0, 1'b1, 2'b00, 32'hAAAA_0000, 32'hBBBB_0000, 0, 32'h0);
    waitDrain();
    checkOutput("t2_wdata_regb", 64'(last_wdata), 64'h1);
    applyStimulus(32'h0000_0208, 32'h1, 64'h7, 1'b0, 1'b1, 2'b10, 32'hAAAA_0000, 32'hBBBB_0000, 0, 32'h0);
    waitDrain();
    checkOutput("t2_wdata_ch1", 64'(last_wdata), 64'hBBBB_0000);

    $display("[TB] loads");
    applyStimulus(32'h0000_0100, 32'h0, 64'h8, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 3, 32'hDEAD_BEEF);
    waitDrain();
    checkOutput("t3_rdata", 64'(done_rdata), 64'hDEAD_BEEF);
    checkOutput("t3_err", 64'(done_err), 64'd0);
    checkOutput("t3_lat", 64'(done_lat), 64'd5);
    checkOutput("t3_addr", 64'(last_addr), 64'h100);
    checkOutput("t3_we", 64'(last_we), 64'd0);
    applyStimulus(32'h0000_0110, 32'h0, 64'h9, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, -1, 32'h0);
    waitDrain();
    checkOutput("t4_err", 64'(done_err), 64'd1);
    checkOutput("t4_rdata", 64'(done_rdata), 64'd0);
    checkOutput("t4_lat", 64'(done_lat), 64'(TIMEOUT + 2));
    applyStimulus(32'h0000_0120, 32'h0, 64'hA, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1, 32'h0000_0001);
    waitDrain();
    checkOutput("load_min_lat", 64'(done_lat), 64'd3);
    applyStimulus(32'h0000_0130, 32'h0, 64'hB, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, TIMEOUT, 32'hCAFE_F00D);
    waitDrain();
    checkOutput("load_last_cycle_err", 64'(done_err), 64'd0);
    checkOutput("load_last_cycle_rdata", 64'(done_rdata), 64'hCAFE_F00D);
    applyStimulus(32'h0000_0140, 32'h0, 64'hC, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, TIMEOUT + 1, 32'h7777_7777);
    waitDrain();
    checkOutput("load_late_err", 64'(done_err), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(32'h0000_0150, 32'h9, 64'hD, 1'b1, 1'b1, 2'b01, 32'h5, 32'h0, 2, 32'h1357_9BDF);
    waitDrain();
    checkOutput("ld_st_as_load_we", 64'(last_we), 64'd0);
    checkOutput("ld_st_as_load_rdata", 64'(done_rdata), 64'h1357_9BDF);

    $display("[TB] stall then back-to-back");
    out_ready = 1'b0;
    applyStimulus(32'h5555_0001, 32'h0, 64'hE, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 0, 32'h0);
    fork
      applyStimulus(32'h6666_0002, 32'h0, 64'hF, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 0, 32'h0);
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          checkOutput("t5_in_ready_low", 64'(in_ready), 64'd0);
          checkOutput("t5_hold_valid", 64'(out_valid), 64'd1);
          checkOutput("t5_hold_alu", 64'(out_alu), 64'h5555_0001);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    @(negedge clk);
    checkOutput("t5_b2b_valid", 64'(out_valid), 64'd1);
    checkOutput("t5_b2b_alu", 64'(out_alu), 64'h6666_0002);
    waitDrain();

    $display("[TB] mixed burst");
    applyStimulus(32'h0000_0300, 32'h21, 64'h10, 1'b0, 1'b1, 2'b10, 32'h0, 32'h2222_2222, 0, 32'h0);
    applyStimulus(32'h0000_0304, 32'h0, 64'h11, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 2, 32'h0BAD_F00D);
    applyStimulus(32'h0000_0308, 32'h0, 64'h12, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 0, 32'h0);
    applyStimulus(32'h0000_030C, 32'h33, 64'h13, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 0, 32'h0);
    waitDrain();

    $display("[TB] reset during wait");
    applyStimulus(32'h0000_0400, 32'h0, 64'h14, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 8, 32'h1234_5678);
    repeat (3) @(posedge clk);
    #1 applyReset();
    @(negedge clk);
    checkOutput("t6_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("t6_rst_alu", 64'(out_alu), 64'd0);
    checkOutput("t6_rst_ctrl", out_ctrl, 64'd0);
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("t6_idle_ready", 64'(in_ready), 64'd1);
      checkOutput("t6_idle_valid", 64'(out_valid), 64'd0);
      checkOutput("t6_idle_rdata", 64'(out_rdata), 64'd0);
      checkOutput("t6_idle_mem_req", 64'(mem_req), 64'd0);
    end
    @(posedge clk);
    #1;
    applyStimulus(32'h0000_0500, 32'h0, 64'h15, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 0, 32'h0);
    waitDrain();
    checkOutput("t6_recover_alu", 64'(done_alu), 64'h500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
